// File: rtl/meas_window_ctrl.sv
// Measurement window controller for the adc_to_vga min/max amplitude tracker.
// Frames samples into windows, gates the tracker and hands results out via valid/ready.
module meas_window_ctrl #(
  parameter int DATA_W      = 12,
  parameter int OFS_W       = 14,
  parameter int WIN_SAMPLES = 4096,
  parameter int CNT_W       = 26,
  parameter int DRAIN_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              sample_valid,
  output logic              trk_clear,
  output logic              trk_en,
  input  logic [DATA_W-1:0] trk_amp,
  input  logic [OFS_W-1:0]  trk_offset,
  output logic [DATA_W-1:0] res_amp,
  output logic [OFS_W-1:0]  res_offset,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              overrun,
  output logic              busy
);

  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_SAMPLES - 1);
  localparam logic [DW-1:0]    DRN_LAST = DW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, ACQ, DRAIN, LATCH
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    dcnt;
  logic             run_q;
  logic             win_done;
  logic             drn_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    trk_clear = 1'b0;
    trk_en    = 1'b0;
    busy      = 1'b1;
    win_done  = 1'b0;
    drn_done  = (dcnt == DRN_LAST);
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (run) state_n = CLEAR;
      end
      CLEAR: begin
        trk_clear = 1'b1;
        state_n   = run ? ACQ : IDLE;
      end
      ACQ: begin
        trk_en   = run && sample_valid;
        win_done = trk_en && (cnt == WIN_LAST);
        if (!run)         state_n = IDLE;
        else if (win_done) state_n = DRAIN;
      end
      DRAIN: begin
        if (!run)          state_n = IDLE;
        else if (drn_done) state_n = LATCH;
      end
      LATCH: begin
        state_n = run ? CLEAR : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dcnt <= '0;
    end else begin
      if (state == CLEAR) cnt <= '0;
      else if (trk_en)    cnt <= cnt + 1'b1;
      if (state == DRAIN) dcnt <= dcnt + 1'b1;
      else                dcnt <= '0;
    end
  end

  // overrun is cleared by a falling run edge, which wins over a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      res_amp    <= '0;
      res_offset <= '0;
      res_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      run_q <= run;
      if (state == LATCH) begin
        res_amp    <= trk_amp;
        res_offset <= trk_offset;
        res_valid  <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      if (run_q && !run)
        overrun <= 1'b0;
      else if (state == LATCH && res_valid && !res_ready)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_meas_window_ctrl.sv
// Bench for meas_window_ctrl: directed scenarios plus random traffic
// against a window-timeline reference model.
module tb_meas_window_ctrl;

  localparam int WIN = 8;
  localparam int DRN = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        sample_valid;
  logic        trk_clear;
  logic        trk_en;
  logic [11:0] trk_amp;
  logic [13:0] trk_offset;
  logic [11:0] res_amp;
  logic [13:0] res_offset;
  logic        res_valid;
  logic        res_ready;
  logic        overrun;
  logic        busy;

  meas_window_ctrl #(
    .DATA_W(12), .OFS_W(14), .WIN_SAMPLES(WIN),
    .CNT_W(26), .DRAIN_CYC(DRN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .sample_valid(sample_valid),
    .trk_clear(trk_clear), .trk_en(trk_en),
    .trk_amp(trk_amp), .trk_offset(trk_offset),
    .res_amp(res_amp), .res_offset(res_offset),
    .res_valid(res_valid), .res_ready(res_ready),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model: window timeline (t = cycles since window's clear cycle)
  bit          m_active;
  int          m_t, m_acc, m_tend;
  logic [11:0] m_amp;
  logic [13:0] m_ofs;
  bit          m_valid, m_ovr, m_run_prev;

  int cyc_n, en_cnt, n_latch, last_en, gap_max;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit latch_now();
    return m_active && m_acc == WIN && m_t == m_tend + DRN + 1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_t = 0; m_acc = 0; m_tend = -1;
    m_amp = '0; m_ofs = '0;
    m_valid = 0; m_ovr = 0; m_run_prev = 0;
  endtask

  task automatic check_all(input bit e_en);
    chk("busy", busy, m_active);
    chk("trk_clear", trk_clear, m_active && m_t == 0);
    chk("trk_en", trk_en, e_en);
    chk("res_valid", res_valid, m_valid);
    chk("res_amp", res_amp, m_amp);
    chk("res_offset", res_offset, m_ofs);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic cyc(input bit r, input bit s, input bit y,
                     input logic [11:0] a, input logic [13:0] o);
    bit e_en, lt, fall;
    run = r; sample_valid = s; res_ready = y;
    trk_amp = a; trk_offset = o;
    #1;
    e_en = m_active && m_t > 0 && m_acc < WIN && s && r;
    lt   = latch_now();
    check_all(e_en);
    cyc_n++;
    if (trk_en) begin
      en_cnt++;
      if (last_en >= 0 && cyc_n - last_en - 1 > gap_max)
        gap_max = cyc_n - last_en - 1;
      last_en = cyc_n;
    end
    if (lt) n_latch++;
    fall = m_run_prev && !r;
    if (lt) begin
      if (m_valid && !y && !fall) m_ovr = 1;
      m_amp = a; m_ofs = o; m_valid = 1;
    end else if (m_valid && y) begin
      m_valid = 0;
    end
    if (fall) m_ovr = 0;
    m_run_prev = r;
    if (!m_active) begin
      if (r) begin m_active = 1; m_t = 0; m_acc = 0; m_tend = -1; end
    end else if (lt) begin
      if (r) begin m_t = 0; m_acc = 0; m_tend = -1; end
      else m_active = 0;
    end else if (!r) begin
      m_active = 0;
    end else begin
      if (e_en) begin
        m_acc++;
        if (m_acc == WIN) m_tend = m_t;
      end
      m_t++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [11:0] ra();
    return 12'($urandom);
  endfunction

  function automatic logic [13:0] ro();
    return 14'($urandom);
  endfunction

  initial begin
    rst_n = 1'b0; run = 0; sample_valid = 0; res_ready = 0;
    trk_amp = '0; trk_offset = '0;
    model_reset();
    cyc_n = 0; en_cnt = 0; n_latch = 0; last_en = -1; gap_max = 0;
    repeat (2) @(negedge clk);
    check_all(1'b0);
    rst_n = 1'b1;
    repeat (2) cyc(0, 1, 0, ra(), ro());

    // back-to-back windows, sample every cycle
    en_cnt = 0; n_latch = 0; last_en = -1; gap_max = 0;
    for (int i = 0; i < 100 && n_latch < 2; i++) cyc(1, 1, 1, ra(), ro());
    chk("t1_latches", n_latch, 2);
    chk("t1_en_count", en_cnt, 2 * WIN);
    chk("t1_gap", gap_max, 2 + DRN);

    // sparse samples, constant tracker values
    en_cnt = 0; n_latch = 0;
    for (int i = 0; i < 200 && n_latch < 2; i++)
      cyc(1, (i % 3) == 0, 1, 12'h3A0, 14'h200);
    chk("t2_en_count", en_cnt, 2 * WIN);
    chk("t2_amp", res_amp, 12'h3A0);
    chk("t2_ofs", res_offset, 14'h200);

    // consumer stalled across two windows
    n_latch = 0;
    for (int i = 0; i < 200 && n_latch < 2; i++)
      cyc(1, 1'($urandom), 0, ra(), ro());
    chk("t3_overrun", overrun, 1);
    cyc(0, 0, 0, ra(), ro());
    cyc(0, 0, 0, ra(), ro());
    chk("t3_ovr_clr", overrun, 0);
    chk("t3_held", res_valid, 1);
    cyc(0, 0, 1, ra(), ro());
    cyc(0, 0, 0, ra(), ro());
    chk("t3_accepted", res_valid, 0);

    // ready exactly at the latch cycle of a pending result
    n_latch = 0;
    for (int i = 0; i < 200 && n_latch < 1; i++)
      cyc(1, 1'($urandom), 0, ra(), ro());
    for (int i = 0; i < 200 && n_latch < 2; i++)
      cyc(1, 1'($urandom), latch_now(), ra(), ro());
    chk("t4_valid", res_valid, 1);
    chk("t4_overrun", overrun, 0);

    // abort after five samples
    repeat (3) cyc(0, 0, 1, ra(), ro());
    en_cnt = 0; n_latch = 0;
    for (int i = 0; i < 50 && en_cnt < 5; i++) cyc(1, 1, 1, ra(), ro());
    cyc(0, 1, 1, ra(), ro());
    repeat (6) cyc(0, 1, 1, ra(), ro());
    chk("t5_en_count", en_cnt, 5);
    chk("t5_no_valid", res_valid, 0);
    chk("t5_idle", busy, 0);

    // async reset mid-ACQ and mid-DRAIN
    for (int i = 0; i < 50 && !(m_active && m_t > 0 && m_acc >= 3); i++)
      cyc(1, 1, 1, ra(), ro());
    do_reset();
    repeat (4) cyc(1, 1, 1, ra(), ro());
    for (int i = 0; i < 50 && !(m_acc == WIN && m_t > m_tend && !latch_now()); i++)
      cyc(1, 1, 1, ra(), ro());
    chk("t6_in_drain", m_acc == WIN && m_t > m_tend, 1);
    do_reset();
    repeat (4) cyc(1, 1'($urandom), 1, ra(), ro());

    // random traffic
    for (int i = 0; i < 600; i++)
      cyc(($urandom % 16) != 0, 1'($urandom), ($urandom % 3) != 0, ra(), ro());

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
